unsaved_led_sequencer: RTL

//  Avalon-MM slave LED controller in the Nios system; replaces the plain LED PIO at the board pins.

---
 rtl/unsaved_led_seq_pkg.sv | 29 ++
 rtl/unsaved_led_seq_timer.sv | 25 ++
 rtl/unsaved_led_sequencer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/unsaved_led_seq_pkg.sv
// Shared constants for the LED sequencer: register map, CTRL/STATUS bit positions, FSM states.
package unsaved_led_seq_pkg;

  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_DIRECT   = 3'd1;
  localparam logic [2:0] REG_PERIOD   = 3'd2;
  localparam logic [2:0] REG_PAT_ADDR = 3'd3;
  localparam logic [2:0] REG_PAT_DATA = 3'd4;
  localparam logic [2:0] REG_LENGTH   = 3'd5;
  localparam logic [2:0] REG_STATUS   = 3'd6;

  localparam int unsigned CTRL_RUN    = 0;
  localparam int unsigned CTRL_LOOP   = 1;
  localparam int unsigned CTRL_MODE   = 2;
  localparam int unsigned CTRL_CLR    = 3;
  localparam int unsigned CTRL_IRQ_EN = 4;

  localparam int unsigned STAT_BUSY = 0;
  localparam int unsigned STAT_DONE = 1;
  localparam int unsigned STAT_IRQ  = 2;
  localparam int unsigned STAT_IDX  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/unsaved_led_seq_timer.sv
// Step-rate counter: pulses step once every max(period,1) cycles while clr is low.
module unsaved_led_seq_timer #(
  parameter int unsigned PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clr,
  input  logic [PERIOD_W-1:0] period,
  output logic                step
);

  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] limit;

  assign limit = (period == '0) ? PERIOD_W'(1) : period;
  // >= so a live PERIOD shrink below cnt still ends the step instead of wrapping
  assign step  = !clr && (cnt >= limit - PERIOD_W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         cnt <= '0;
    else if (clr || step) cnt <= '0;
    else                  cnt <= cnt + PERIOD_W'(1);
  end

endmodule

// File: rtl/unsaved_led_sequencer.sv
// Avalon-MM LED controller with direct drive and a programmable pattern player.
// Optional completion interrupt enabled by defining UNSAVED_LED_SEQ_IRQ_EN.
module unsaved_led_sequencer
  import unsaved_led_seq_pkg::*;
#(
  parameter int unsigned       LED_W      = 4,
  parameter int unsigned       DEPTH      = 16,
  parameter int unsigned       PERIOD_W   = 24,
  parameter logic [LED_W-1:0]  RESET_LEDS = 4'h7
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [LED_W-1:0] out_port,
  output logic             irq
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned LEN_W = IDX_W + 1;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                loop_q, mode_q, irq_en;
  logic [LED_W-1:0]    direct_q;
  logic [PERIOD_W-1:0] period_q;
  logic [IDX_W-1:0]    pat_addr_q;
  logic [LEN_W-1:0]    length_q;
  logic [LED_W-1:0]    pat_mem [DEPTH];
  logic [LED_W-1:0]    out_d;

  logic wr, wr_ctrl, start_ok, abort, step, at_last, busy, done;
  logic [IDX_W-1:0] last_idx;
  logic unused_wd;

  assign wr        = chipselect & ~write_n;
  assign wr_ctrl   = wr && (address == REG_CTRL);
  assign start_ok  = wr_ctrl && writedata[CTRL_RUN] && writedata[CTRL_MODE] && (length_q != '0);
  assign abort     = wr_ctrl && !(writedata[CTRL_RUN] && writedata[CTRL_MODE]);
  assign at_last   = ({1'b0, idx_q} + LEN_W'(1)) >= length_q;
  assign last_idx  = IDX_W'(length_q - LEN_W'(1));
  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign unused_wd = ^writedata;

  unsaved_led_seq_timer #(.PERIOD_W(PERIOD_W)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (!busy),
    .period  (period_q),
    .step    (step)
  );

  // The run bit is just the RUN state, so an unsuccessful start reads back as 0.
  // Completion outranks an abort/done-clear write landing in the same cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d = ST_RUN;
          idx_d   = '0;
        end
      end
      ST_RUN: begin
        if (step && at_last && !loop_q) state_d = ST_DONE;
        else if (abort)                 state_d = ST_IDLE;
        else if (step)                  idx_d   = at_last ? '0 : idx_q + IDX_W'(1);
      end
      ST_DONE: begin
        if (start_ok) begin
          state_d = ST_RUN;
          idx_d   = '0;
        end else if (wr_ctrl && writedata[CTRL_CLR]) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    out_d = direct_q;
    case (state_q)
      ST_RUN:  out_d = pat_mem[idx_q];
      ST_DONE: out_d = pat_mem[last_idx];
      default: out_d = direct_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      loop_q     <= 1'b0;
      mode_q     <= 1'b0;
      direct_q   <= RESET_LEDS;
      period_q   <= PERIOD_W'(1);
      pat_addr_q <= '0;
      length_q   <= '0;
      out_port   <= RESET_LEDS;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      out_port <= out_d;
      if (wr_ctrl) begin
        loop_q <= writedata[CTRL_LOOP];
        mode_q <= writedata[CTRL_MODE];
      end
      if (wr && address == REG_DIRECT) direct_q <= writedata[LED_W-1:0];
      if (wr && address == REG_PERIOD) period_q <= writedata[PERIOD_W-1:0];
      if (wr && address == REG_PAT_ADDR)      pat_addr_q <= writedata[IDX_W-1:0];
      else if (wr && address == REG_PAT_DATA) pat_addr_q <= pat_addr_q + IDX_W'(1);
      if (wr && address == REG_LENGTH) begin
        if (writedata > 32'(DEPTH)) length_q <= LEN_W'(DEPTH);
        else                        length_q <= writedata[LEN_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr && address == REG_PAT_DATA) pat_mem[pat_addr_q] <= writedata[LED_W-1:0];
  end

`ifdef UNSAVED_LED_SEQ_IRQ_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     irq_en <= 1'b0;
    else if (wr_ctrl) irq_en <= writedata[CTRL_IRQ_EN];
  end
  assign irq = done & irq_en;
`else
  assign irq_en = 1'b0;
  assign irq    = 1'b0;
`endif

  always_comb begin
    readdata = '0;
    case (address)
      REG_CTRL: begin
        readdata[CTRL_RUN]    = busy;
        readdata[CTRL_LOOP]   = loop_q;
        readdata[CTRL_MODE]   = mode_q;
        readdata[CTRL_IRQ_EN] = irq_en;
      end
      REG_DIRECT:   readdata[LED_W-1:0]    = direct_q;
      REG_PERIOD:   readdata[PERIOD_W-1:0] = period_q;
      REG_PAT_ADDR: readdata[IDX_W-1:0]    = pat_addr_q;
      REG_PAT_DATA: readdata[LED_W-1:0]    = pat_mem[pat_addr_q];
      REG_LENGTH:   readdata[LEN_W-1:0]    = length_q;
      REG_STATUS: begin
        readdata[STAT_BUSY]           = busy;
        readdata[STAT_DONE]           = done;
        readdata[STAT_IRQ]            = irq;
        readdata[STAT_IDX +: IDX_W]   = idx_q;
      end
      default: readdata = '0;
    endcase
  end

endmodule
